vram_arbiter: RTL and testbench

Shares one single-port synchronous video RAM between two users: the display fetch path, paced by the timing controller's RGB_EN/V_SYNC, and a host write port. Display reads have absolute priority during visible pixels. Host writes are buffered in a small FIFO and drained during blanking. Sits between the timing controller, the frame-buffer RAM and the RGB DAC output stage.

---
 rtl/vram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous video RAM between the display fetch path
// and a host write port. Display reads own the RAM whenever RGB_EN is high.
// Host writes are queued in a small FIFO and retired while RGB_EN is low
// (blanking). Host writes to addresses at or beyond PIX_COUNT are popped and
// discarded without touching the RAM.
//
// Optional feature macro: VRAM_STATS_EN
//   When defined, adds WR_DROP (sticky "out-of-range write discarded") and
//   WR_STALL (registered HOST_VALID && !HOST_READY).
//
// Ports
//   CLK         in   pixel clock (shared with the timing controller)
//   NRST        in   asynchronous active-low reset
//   RGB_EN      in   visible pixel time
//   V_SYNC      in   active-low vertical sync; clears the display address
//   PIX_DATA    out  registered pixel to the DAC, 0 during blanking
//   PIX_EN      out  RGB_EN delayed by 2 cycles, qualifies PIX_DATA
//   HOST_ADDR   in   host write address
//   HOST_DATA   in   host write data
//   HOST_VALID  in   host write request
//   HOST_READY  out  FIFO can accept a write (registered, equals !full)
//   MEM_ADDR    out  registered RAM address
//   MEM_WDATA   out  registered RAM write data
//   MEM_WE      out  registered RAM write enable
//   MEM_RDATA   in   RAM read data, valid in the cycle after the cycle in
//                    which the read address was issued (i.e. while MEM_ADDR
//                    carries that address)
//   WR_DROP     out  (VRAM_STATS_EN) sticky out-of-range drop flag
//   WR_STALL    out  (VRAM_STATS_EN) registered host stall indication
// ---------------------------------------------------------------------------

// Invariant checker for the arbiter, kept apart from the datapath.
module vram_arbiter_chk (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic rgb_en_i,
    input  logic mem_we_i,
    input  logic host_ready_i,
    input  logic fifo_full_i,
    input  logic fifo_empty_i,
    input  logic pop_i
);

    // A visible-pixel cycle always owns the RAM: no write may follow it.
    a_no_write_after_fetch: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        $past(rgb_en_i) |-> !mem_we_i);

    // The ready flag must never advertise space in a full FIFO.
    a_ready_not_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        host_ready_i |-> !fifo_full_i);

    // Entries are only popped from a non-empty FIFO.
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        pop_i |-> !fifo_empty_i);

endmodule

module vram_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int PIX_COUNT  = 307200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              NRST,
    input  logic              RGB_EN,
    input  logic              V_SYNC,
    output logic [DATA_W-1:0] PIX_DATA,
    output logic              PIX_EN,
    input  logic [ADDR_W-1:0] HOST_ADDR,
    input  logic [DATA_W-1:0] HOST_DATA,
    input  logic              HOST_VALID,
    output logic              HOST_READY,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
`ifdef VRAM_STATS_EN
    output logic              WR_DROP,
    output logic              WR_STALL,
`endif
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(PIX_COUNT - 1);
    // One extra bit so the range compare is safe even if PIX_COUNT == 2**ADDR_W.
    localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W + 1)'(PIX_COUNT);
    localparam logic [PTR_W:0]    PTR_ZERO  = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W:0]    PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // Bit 0 of the state is the RAM write enable, so MEM_WE comes straight
    // off a flop with no decode. FETCH/DROP never write.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_WRITE = 3'b001,
        ST_FETCH = 3'b010,
        ST_DROP  = 3'b100
    } state_e;

    state_e state_q;
    state_e state_d;

    // Host write FIFO storage and pointers (MSB distinguishes full from empty).
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q;
    logic [PTR_W:0]    wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q;
    logic [PTR_W:0]    rd_ptr_d;
    logic              ready_q;
    logic              full_d_s;
    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_data_s;
    logic              head_in_range_s;

    // RAM-side and display registers.
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [ADDR_W-1:0] disp_addr_q;
    logic [ADDR_W-1:0] disp_addr_d;
    logic              en_d1_q;
    logic              en_d2_q;
    logic [DATA_W-1:0] pix_data_q;
    logic              mem_we_s;

    // FIFO status and head-of-queue view.
    always_comb begin
        empty_s         = (wr_ptr_q == rd_ptr_q);
        full_s          = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                          (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        head_addr_s     = fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
        head_data_s     = fifo_data_q[rd_ptr_q[PTR_W-1:0]];
        head_in_range_s = ({1'b0, head_addr_s} < PIX_LIMIT);
        push_s          = HOST_VALID && ready_q && !full_s;
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: RGB_EN wins unconditionally, otherwise drain the FIFO.
    always_comb begin
        state_d = ST_IDLE;
        if (RGB_EN) begin
            state_d = ST_FETCH;
        end else if (!empty_s) begin
            if (head_in_range_s) begin
                state_d = ST_WRITE;
            end else begin
                state_d = ST_DROP;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // FSM outputs: write enable from the state flop, pop on any drain decision.
    always_comb begin
        mem_we_s = state_q[0];
        pop_s    = (state_d == ST_WRITE) || (state_d == ST_DROP);
    end

    // Next values of the RAM bus, display address and FIFO pointers.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        disp_addr_d = disp_addr_q;
        case (state_d)
            ST_FETCH: begin
                mem_addr_d  = disp_addr_q;
                disp_addr_d = (disp_addr_q == PIX_LAST) ? ADDR_ZERO : (disp_addr_q + ADDR_ONE);
            end
            ST_WRITE: begin
                mem_addr_d  = head_addr_s;
                mem_wdata_d = head_data_s;
            end
            default: begin
                mem_addr_d  = mem_addr_q;
                mem_wdata_d = mem_wdata_q;
            end
        endcase
        // Frame restart overrides any increment.
        if (!V_SYNC) begin
            disp_addr_d = ADDR_ZERO;
        end else begin
            disp_addr_d = disp_addr_d;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Ready is registered from the post-update occupancy, so it stays low
        // for the whole cycle in which the FIFO is full, pop or not.
        full_d_s = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                   (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= HOST_ADDR;
            fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= HOST_DATA;
        end
    end

    // RAM bus, display address, FIFO pointers and ready flag.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            mem_addr_q  <= ADDR_ZERO;
            mem_wdata_q <= DATA_ZERO;
            disp_addr_q <= ADDR_ZERO;
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            ready_q     <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            disp_addr_q <= disp_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ready_q     <= !full_d_s;
        end
    end

    // Two-stage display pipeline: address issue, RAM data, registered pixel.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            en_d1_q    <= 1'b0;
            en_d2_q    <= 1'b0;
            pix_data_q <= DATA_ZERO;
        end else begin
            en_d1_q    <= RGB_EN;
            en_d2_q    <= en_d1_q;
            pix_data_q <= en_d1_q ? MEM_RDATA : DATA_ZERO;
        end
    end

`ifdef VRAM_STATS_EN
    logic drop_q;
    logic stall_q;

    // Sticky drop flag and registered stall indication.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            drop_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            drop_q  <= drop_q || (state_d == ST_DROP);
            stall_q <= HOST_VALID && !ready_q;
        end
    end

    assign WR_DROP  = drop_q;
    assign WR_STALL = stall_q;
`endif

    assign PIX_DATA   = pix_data_q;
    assign PIX_EN     = en_d2_q;
    assign HOST_READY = ready_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_WDATA  = mem_wdata_q;
    assign MEM_WE     = mem_we_s;

    vram_arbiter_chk u_chk (
        .clk_i        (CLK),
        .rst_n_i      (NRST),
        .rgb_en_i     (RGB_EN),
        .mem_we_i     (MEM_WE),
        .host_ready_i (HOST_READY),
        .fifo_full_i  (full_s),
        .fifo_empty_i (empty_s),
        .pop_i        (pop_s)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter. A queue-based reference model predicts
// every registered output each cycle; outputs are compared on the falling edge.
module tb_vram_arbiter;

    // Scaled-down frame so a full frame (and the wrap) is short.
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int PIX   = 600;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          NRST = 1'b0;
    logic          RGB_EN = 1'b0;
    logic          V_SYNC = 1'b1;
    logic [DW-1:0] PIX_DATA;
    logic          PIX_EN;
    logic [AW-1:0] HOST_ADDR = '0;
    logic [DW-1:0] HOST_DATA = '0;
    logic          HOST_VALID = 1'b0;
    logic          HOST_READY;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic          MEM_WE;
    logic [DW-1:0] MEM_RDATA;
`ifdef VRAM_STATS_EN
    logic          WR_DROP;
    logic          WR_STALL;
`endif

    vram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .PIX_COUNT  (PIX),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK        (CLK),
        .NRST       (NRST),
        .RGB_EN     (RGB_EN),
        .V_SYNC     (V_SYNC),
        .PIX_DATA   (PIX_DATA),
        .PIX_EN     (PIX_EN),
        .HOST_ADDR  (HOST_ADDR),
        .HOST_DATA  (HOST_DATA),
        .HOST_VALID (HOST_VALID),
        .HOST_READY (HOST_READY),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_WE     (MEM_WE),
`ifdef VRAM_STATS_EN
        .WR_DROP    (WR_DROP),
        .WR_STALL   (WR_STALL),
`endif
        .MEM_RDATA  (MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    // Frame-buffer RAM driven by the DUT bus.
    logic [DW-1:0] ram [1024];
    assign MEM_RDATA = ram[MEM_ADDR];

    // RAM write port.
    always @(posedge CLK) begin
        if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           mq[$];
    wr_t           m_e;
    logic [DW-1:0] ref_ram [1024];
    int            m_disp = 0;
    int            m_fetch_addr = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_ready = 1'b0;
    logic          m_en1 = 1'b0;
    logic          m_pix_en = 1'b0;
    logic [DW-1:0] m_pix = '0;
    logic          m_pend = 1'b0;
    logic [AW-1:0] m_pend_a = '0;
    logic [DW-1:0] m_pend_d = '0;
    logic          m_drop = 1'b0;
    logic          m_stall = 1'b0;
    logic          m_was_ready;

    // Model: display priority, FIFO drain in blanking, 2-cycle pixel pipe.
    always @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            mq.delete();
            m_disp = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_ready = 1'b0;
            m_en1 = 1'b0; m_pix_en = 1'b0; m_pix = '0; m_pend = 1'b0;
            m_drop = 1'b0; m_stall = 1'b0;
        end else begin
            // A write issued last cycle lands in the RAM on this edge.
            if (m_pend) ref_ram[m_pend_a] = m_pend_d;
            m_pend = 1'b0;
            m_pix = m_en1 ? ref_ram[m_fetch_addr] : '0;
            m_pix_en = m_en1;
            m_en1 = RGB_EN;
            m_was_ready = m_ready;
            m_stall = HOST_VALID && !m_was_ready;
            m_we = 1'b0;
            if (RGB_EN) begin
                m_addr = AW'(m_disp);
                m_fetch_addr = m_disp;
                m_disp = (m_disp + 1) % PIX;
            end else if (mq.size() > 0) begin
                m_e = mq.pop_front();
                if (int'(m_e.a) < PIX) begin
                    m_we = 1'b1; m_addr = m_e.a; m_wdata = m_e.d;
                    m_pend = 1'b1; m_pend_a = m_e.a; m_pend_d = m_e.d;
                end else begin
                    m_drop = 1'b1;
                end
            end
            if (!V_SYNC) m_disp = 0;
            if (HOST_VALID && m_was_ready) mq.push_back({HOST_ADDR, HOST_DATA});
            m_ready = (mq.size() < DEPTH);
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("mem_we",     32'(MEM_WE),     32'(m_we));
        check_eq("mem_addr",   32'(MEM_ADDR),   32'(m_addr));
        check_eq("mem_wdata",  32'(MEM_WDATA),  32'(m_wdata));
        check_eq("host_ready", 32'(HOST_READY), 32'(m_ready));
        check_eq("pix_en",     32'(PIX_EN),     32'(m_pix_en));
        check_eq("pix_data",   32'(PIX_DATA),   32'(m_pix));
`ifdef VRAM_STATS_EN
        check_eq("wr_drop",    32'(WR_DROP),    32'(m_drop));
        check_eq("wr_stall",   32'(WR_STALL),   32'(m_stall));
`endif
    endtask

    // Drive one cycle of inputs, let the edge pass, compare on the falling edge.
    task automatic cyc(input logic rgb, input logic vs, input logic hv, input int a, input int d);
        RGB_EN = rgb; V_SYNC = vs; HOST_VALID = hv;
        HOST_ADDR = AW'(a); HOST_DATA = DW'(d);
        @(negedge CLK);
        compare_all();
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(PIX, 1023));
        return int'($urandom_range(0, PIX - 1));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic rgb_r;
        for (int i = 0; i < 1024; i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            ram[i] <= v;
            ref_ram[i] = v;
        end

        // Reset state.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);
        NRST = 1'b1;
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);

        // Blanking drain of two writes, then idle.
        cyc(1'b0, 1'b1, 1'b1, 5, 8'hAA);
        cyc(1'b0, 1'b1, 1'b1, 6, 8'h55);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);

        // Fetch priority: queue 4 writes during 640 visible cycles.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 100 + i, 8'hC0 + i);
        for (int i = 0; i < 636; i++) cyc(1'b1, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);

        // Display pipeline from a fresh frame.
        for (int i = 0; i < 4; i++) begin
            ram[i] <= DW'(8'h10 + i);
            ref_ram[i] = DW'(8'h10 + i);
        end
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);

        // Wrap: a full frame of fetches then one more, then an out-of-range write.
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < PIX + 1; i++) cyc(1'b1, 1'b1, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 1'b1, PIX, 8'h77);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);

        // Simultaneous push/pop with two entries queued.
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b1, 200 + i, 8'h30 + i);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b1, 300 + i, 8'h40 + i);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);

        // Randomised traffic with bursty RGB_EN and occasional frame restarts.
        rgb_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) rgb_r = ~rgb_r;
            cyc(rgb_r, ($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)),
                rand_addr(), int'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);

        // Reset in the middle of a drain with 3 entries queued.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 400 + i, 8'h90 + i);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        NRST = 1'b0;
        #1;
        compare_all();
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);
        NRST = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
